// File: rtl/jk_bank_driver.sv
// Write-side controller for a bank of external JK flip-flops: computes J/K excitation
// from Q feedback, drives for one cycle, verifies, retries, and flags exhausted retries.
module jk_bank_driver #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DC_MODE   = 0,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        VERIFY
    } state_t;

    localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] target, target_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic [WIDTH-1:0] tgt_sel, exc_j, exc_k;
    logic [2:0]       retry, retry_nxt;
    logic             done_nxt, err_nxt;
    logic [7:0]       err_cnt_nxt;

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state != IDLE);

    // In IDLE the excitation is built from the incoming word; later from the latched target.
    assign tgt_sel = (state == IDLE) ? in_data : target;

    always_comb begin
        if (DC_MODE == 0) begin
            exc_j = ~q_fb & tgt_sel;
            exc_k = q_fb & ~tgt_sel;
        end else begin
            exc_j = q_fb | tgt_sel;
            exc_k = ~(q_fb & tgt_sel);
        end
    end

    always_comb begin
        state_nxt   = state;
        target_nxt  = target;
        j_nxt       = '0;
        k_nxt       = '0;
        retry_nxt   = retry;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        err_cnt_nxt = err_cnt;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    target_nxt = in_data;
                    j_nxt      = exc_j;
                    k_nxt      = exc_k;
                    retry_nxt  = '0;
                    state_nxt  = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = VERIFY;
            end
            VERIFY: begin
                if (q_fb == target) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (retry < RETRY_LIM) begin
                    retry_nxt = retry + 3'd1;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt_nxt = err_cnt + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            target  <= '0;
            j_out   <= '0;
            k_out   <= '0;
            retry   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            state   <= state_nxt;
            target  <= target_nxt;
            j_out   <= j_nxt;
            k_out   <= k_nxt;
            retry   <= retry_nxt;
            done    <= done_nxt;
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Directed bench for jk_bank_driver: two instances (set/reset fill and toggle-biased fill),
// each wired to a behavioural JK bank with preload and stuck-at-0 injection.
module tb_jk_bank_driver;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: DC_MODE=0
    logic       in_valid_a, in_ready_a, busy_a, done_a, err_a;
    logic [7:0] in_data_a, q_a, j_a, k_a, err_cnt_a;
    logic       ld_a;
    logic [7:0] ld_val_a, stuck_a;

    // Instance B: DC_MODE=1
    logic       in_valid_b, in_ready_b, busy_b, done_b, err_b;
    logic [7:0] in_data_b, q_b, j_b, k_b, err_cnt_b;
    logic       ld_b;
    logic [7:0] ld_val_b;

    jk_bank_driver #(.WIDTH(8), .DC_MODE(0), .MAX_RETRY(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .q_fb(q_a), .j_out(j_a), .k_out(k_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_cnt(err_cnt_a)
    );

    jk_bank_driver #(.WIDTH(8), .DC_MODE(1), .MAX_RETRY(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .q_fb(q_b), .j_out(j_b), .k_out(k_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b)
    );

    // Behavioural JK banks: J=K=1 toggles; stuck bits read as 0.
    always @(posedge clk) begin
        if (ld_a) q_a <= ld_val_a & ~stuck_a;
        else      q_a <= ((j_a & ~q_a) | (~k_a & q_a)) & ~stuck_a;
    end
    always @(posedge clk) begin
        if (ld_b) q_b <= ld_val_b;
        else      q_b <= (j_b & ~q_b) | (~k_b & q_b);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        ld_a = 1'b1; ld_val_a = v;
        step();
        ld_a = 1'b0;
    endtask

    // One request on instance A; returns the err flag seen with done.
    task automatic req_a(input logic [7:0] d, output logic e);
        logic seen;
        seen = 1'b0;
        e = 1'b0;
        in_valid_a = 1'b1; in_data_a = d;
        step();
        in_valid_a = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (done_a) begin
                seen = 1'b1;
                e = err_a;
            end
        end
        if (!seen) check("req_a_timeout", 0, 1);
    endtask

    initial begin
        int         ndrive, nready_bad;
        logic       seen, e;
        int         nerr;

        rst = 1'b1;
        in_valid_a = 1'b1; in_data_a = 8'h00; ld_a = 1'b0; ld_val_a = '0; stuck_a = '0;
        in_valid_b = 1'b1; in_data_b = 8'h00; ld_b = 1'b0; ld_val_b = '0;

        // 1. reset with in_valid asserted
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_in_ready", in_ready_a, 0);
            check("rst_j", j_a, 0);
            check("rst_k", k_a, 0);
            check("rst_err_cnt", err_cnt_a, 0);
        end
        rst = 1'b0; in_valid_a = 1'b0; in_valid_b = 1'b0;
        #1;
        check("post_rst_ready", in_ready_a, 1);

        // 2. DC_MODE=0, 00 -> A5
        load_a(8'h00);
        in_valid_a = 1'b1; in_data_a = 8'hA5;
        step();
        in_valid_a = 1'b0;
        check("t2_busy", busy_a, 1);
        check("t2_ready", in_ready_a, 0);
        check("t2_j", j_a, 8'hA5);
        check("t2_k", k_a, 8'h00);
        step();
        check("t2_q", q_a, 8'hA5);
        check("t2_j_clr", j_a, 8'h00);
        check("t2_done_early", done_a, 0);
        step();
        check("t2_done", done_a, 1);
        check("t2_err", err_a, 0);
        check("t2_ready_back", in_ready_a, 1);
        step();
        check("t2_done_pulse", done_a, 0);

        // 3. DC_MODE=1, F0 -> 3C
        ld_b = 1'b1; ld_val_b = 8'hF0;
        step();
        ld_b = 1'b0;
        in_valid_b = 1'b1; in_data_b = 8'h3C;
        step();
        in_valid_b = 1'b0;
        check("t3_j", j_b, 8'hFC);
        check("t3_k", k_b, 8'hCF);
        step();
        check("t3_q", q_b, 8'h3C);
        step();
        check("t3_done", done_b, 1);
        check("t3_err", err_b, 0);

        // 4. bit0 stuck at 0, target 01: three DRIVE attempts then error
        stuck_a = 8'h01;
        load_a(8'h00);
        in_valid_a = 1'b1; in_data_a = 8'h01;
        step();
        in_valid_a = 1'b0;
        ndrive = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (j_a == 8'h01) ndrive++;
            if (done_a) seen = 1'b1;
            else step();
        end
        check("t4_done", seen, 1);
        check("t4_drives", ndrive, 3);
        check("t4_err", err_a, 1);
        check("t4_err_cnt", err_cnt_a, 1);

        // 5. in_valid held during a request with a different word
        stuck_a = 8'h00;
        in_valid_a = 1'b1; in_data_a = 8'h5A;
        step();
        in_data_a = 8'hFF;
        nready_bad = 0; seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (done_a) seen = 1'b1;
            else if (in_ready_a) nready_bad++;
        end
        in_valid_a = 1'b0;
        check("t5_done", seen, 1);
        check("t5_ready_busy", nready_bad, 0);
        step();
        check("t5_no_second", busy_a, 0);
        check("t5_q", q_a, 8'h5A);

        // 6. reset during DRIVE aborts silently
        in_valid_a = 1'b1; in_data_a = 8'h33;
        step();
        in_valid_a = 1'b0;
        check("t6_in_drive", busy_a, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_j", j_a, 0);
        check("t6_k", k_a, 0);
        check("t6_idle", busy_a, 0);
        check("t6_done", done_a, 0);
        step();
        check("t6_done_after", done_a, 0);
        check("t6_err_cnt", err_cnt_a, 0);

        // 6b. err_cnt saturation
        stuck_a = 8'h01;
        nerr = 0;
        for (int n = 0; n < 256; n++) begin
            req_a(8'h01, e);
            if (e) nerr++;
            if (n == 254) check("sat_254", err_cnt_a, 8'hFF);
        end
        check("sat_nerr", nerr, 256);
        check("sat_err_cnt", err_cnt_a, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
